// File: rtl/noc_pkg.sv
// Shared NoC types: route directions, flit layout,
// and the torus dimension-order routing function.
package noc_pkg;

    typedef enum logic [2:0] {
        DIR_E     = 3'd0,
        DIR_W     = 3'd1,
        DIR_N     = 3'd2,
        DIR_S     = 3'd3,
        DIR_LOCAL = 3'd4
    } dir_e;

    typedef enum logic {
        ARB_OPEN,
        ARB_HELD
    } arb_e;

    localparam int FLIT_X_W = 2;
    localparam int FLIT_Y_W = 2;
    localparam int FLIT_D_W = 32;

    typedef struct packed {
        logic [FLIT_X_W-1:0] x;
        logic [FLIT_Y_W-1:0] y;
        logic [FLIT_D_W-1:0] data;
    } flit_t;

    // X first, then Y; shortest way round each ring, ties go E / N.
    function automatic dir_e torus_route(
        input int unsigned x,
        input int unsigned y,
        input int unsigned xc,
        input int unsigned yc,
        input int unsigned xw,
        input int unsigned yw
    );
        int unsigned xm;
        int unsigned ym;
        int unsigned dx;
        int unsigned dy;
        dir_e        d;
        xm = 32'd1 << xw;
        ym = 32'd1 << yw;
        dx = (x - xc) & (xm - 32'd1);
        dy = (y - yc) & (ym - 32'd1);
        if (dx != 0) begin
            d = (dx <= xm / 2) ? DIR_E : DIR_W;
        end else if (dy != 0) begin
            d = (dy <= ym / 2) ? DIR_N : DIR_S;
        end else begin
            d = DIR_LOCAL;
        end
        return d;
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// Per-VC flit FIFO; full and empty come from the
// registered count, so a push never bypasses a pop.
module vc_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;

    // storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // pointers wrap naturally; count tracks occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_FULL);

endmodule

// File: rtl/inj_port_rx.sv
// Injection port receiver: per-VC buffering, round-robin
// VC arbitration with grant lock, torus route tagging.
module inj_port_rx
    import noc_pkg::*;
#(
    parameter int VC_W  = 1,
    parameter int X_W   = 2,
    parameter int Y_W   = 2,
    parameter int X     = 0,
    parameter int Y     = 0,
    parameter int D_W   = 32,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_v,
    input  logic [VC_W-1:0]       i_vc,
    input  logic [X_W-1:0]        i_x,
    input  logic [Y_W-1:0]        i_y,
    input  logic [D_W-1:0]        i_data,
    output logic                  i_ack,
    output logic                  r_v,
    output logic [VC_W-1:0]       r_vc,
    output logic [X_W-1:0]        r_x,
    output logic [Y_W-1:0]        r_y,
    output logic [D_W-1:0]        r_data,
    output logic [2:0]            r_dir,
    input  logic                  r_rdy,
    output logic [(1<<VC_W)-1:0]  vc_full
);

    localparam int N_VC = 1 << VC_W;
    localparam int FW   = X_W + Y_W + D_W;

    logic [FW-1:0]   head [N_VC];
    logic [N_VC-1:0] empty_v;
    logic [N_VC-1:0] full_v;
    logic [N_VC-1:0] push_v;
    logic [N_VC-1:0] pop_v;

    arb_e            st_q, st_d;
    logic [VC_W-1:0] grant_q, grant_d;
    logic [VC_W-1:0] last_q, last_d;
    logic [VC_W-1:0] pick;
    logic [VC_W-1:0] idx;
    logic [VC_W-1:0] sel;
    logic            any;

    assign i_ack   = rst & i_v & ~full_v[i_vc];
    assign vc_full = full_v;

    for (genvar g = 0; g < N_VC; g++) begin : g_vc
        assign push_v[g] = i_ack & (i_vc == VC_W'(g));
        assign pop_v[g]  = r_v & r_rdy & (sel == VC_W'(g));

        vc_fifo #(
            .W     (FW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push_v[g]),
            .pop   (pop_v[g]),
            .din   ({i_x, i_y, i_data}),
            .dout  (head[g]),
            .empty (empty_v[g]),
            .full  (full_v[g])
        );
    end

    // round-robin search starting one past the last popped VC
    always_comb begin
        pick = last_q;
        idx  = '0;
        any  = 1'b0;
        for (int i = 1; i <= N_VC; i++) begin
            idx = last_q + VC_W'(i);
            if (!any && !empty_v[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

    assign sel  = (st_q == ARB_HELD) ? grant_q : pick;
    assign r_v  = (st_q == ARB_HELD) | any;
    assign r_vc = sel;
    assign {r_x, r_y, r_data} = head[sel];
    assign r_dir = torus_route(32'(r_x), 32'(r_y), X, Y, X_W, Y_W);

    // grant lock: hold a presented flit until the switch takes it
    always_comb begin
        st_d    = st_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (r_v && r_rdy) begin
            st_d   = ARB_OPEN;
            last_d = sel;
        end else if (r_v) begin
            st_d    = ARB_HELD;
            grant_d = sel;
        end
    end

    // arbiter state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q    <= ARB_OPEN;
            grant_q <= '0;
            last_q  <= '0;
        end else begin
            st_q    <= st_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_inj_port_rx.sv
// Scoreboard bench for inj_port_rx at router (1,2):
// directed pushes queue expected flits, a monitor checks pops.
module tb_inj_port_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_v;
    logic [0:0]  i_vc;
    logic [1:0]  i_x;
    logic [1:0]  i_y;
    logic [31:0] i_data;
    logic        i_ack;
    logic        r_v;
    logic [0:0]  r_vc;
    logic [1:0]  r_x;
    logic [1:0]  r_y;
    logic [31:0] r_data;
    logic [2:0]  r_dir;
    logic        r_rdy;
    logic [1:0]  vc_full;

    inj_port_rx #(
        .VC_W(1), .X_W(2), .Y_W(2), .X(1), .Y(2), .D_W(32), .DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .i_v(i_v), .i_vc(i_vc), .i_x(i_x),
        .i_y(i_y), .i_data(i_data), .i_ack(i_ack), .r_v(r_v),
        .r_vc(r_vc), .r_x(r_x), .r_y(r_y), .r_data(r_data),
        .r_dir(r_dir), .r_rdy(r_rdy), .vc_full(vc_full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  x;
        logic [1:0]  y;
        logic [31:0] data;
        logic [2:0]  dir;
    } exp_t;

    localparam logic [2:0] E = 3'd0, W = 3'd1, N = 3'd2, S = 3'd3, L = 3'd4;

    exp_t q0[$];
    exp_t q1[$];
    int   vc_log[$];
    int   pop_cyc[$];
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;

    exp_t        mon_e;
    logic        prev_hold = 1'b0;
    logic [0:0]  prev_vc;
    logic [31:0] prev_data;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: compare every accepted flit with the per-VC queue head
    always @(negedge clk) begin
        if (rst) begin
            if (prev_hold) begin
                check("hold_v", 64'(r_v), 64'd1);
                check("hold_vc", 64'(r_vc), 64'(prev_vc));
                check("hold_data", 64'(r_data), 64'(prev_data));
            end
            if (r_v && r_rdy) begin
                if ((r_vc == 1'b0 && q0.size() == 0) ||
                    (r_vc == 1'b1 && q1.size() == 0)) begin
                    total++;
                    $display("FAIL unexpected_pop: vc %0d data %0h", r_vc, r_data);
                end else begin
                    mon_e = (r_vc == 1'b0) ? q0.pop_front() : q1.pop_front();
                    check("pop_x", 64'(r_x), 64'(mon_e.x));
                    check("pop_y", 64'(r_y), 64'(mon_e.y));
                    check("pop_data", 64'(r_data), 64'(mon_e.data));
                    check("pop_dir", 64'(r_dir), 64'(mon_e.dir));
                end
                vc_log.push_back(int'(r_vc));
                pop_cyc.push_back(cyc);
            end
        end
        prev_hold = rst && r_v && !r_rdy;
        prev_vc   = r_vc;
        prev_data = r_data;
    end

    // drive one flit and hold it until acked; report refused cycles
    task automatic send(input logic vc, input logic [1:0] x,
                        input logic [1:0] y, input logic [31:0] d,
                        input logic [2:0] dir, output int waits);
        bit   done;
        exp_t e;
        done   = 1'b0;
        waits  = 0;
        i_v    = 1'b1;
        i_vc   = vc;
        i_x    = x;
        i_y    = y;
        i_data = d;
        e      = '{x: x, y: y, data: d, dir: dir};
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (i_ack) begin
                if (vc) q1.push_back(e);
                else    q0.push_back(e);
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        i_v = 1'b0;
        if (!done) begin
            total++;
            $display("FAIL send_timeout: vc %0d data %0h never acked", vc, d);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 60 && (q0.size() != 0 || q1.size() != 0); k++)
            @(posedge clk);
        #1;
        check(name, 64'(q0.size() + q1.size()), 64'd0);
    endtask

    int w;
    int exp_seq [6] = '{0, 1, 0, 1, 0, 1};

    initial begin
        rst = 1'b0; i_v = 1'b1; i_vc = 1'b0; i_x = 2'd1; i_y = 2'd2;
        i_data = 32'hA5; r_rdy = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_r_v", 64'(r_v), 64'd0);
        check("rst_i_ack", 64'(i_ack), 64'd0);
        check("rst_vc_full", 64'(vc_full), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        send(1'b0, 2'd1, 2'd2, 32'hA5, L, w);
        check("first_ack_wait", 64'(w), 64'd0);
        @(negedge clk);
        check("first_r_v", 64'(r_v), 64'd1);
        check("first_r_vc", 64'(r_vc), 64'd0);
        check("first_r_dir", 64'(r_dir), 64'(L));
        check("first_r_data", 64'(r_data), 64'hA5);
        @(posedge clk); #1;

        send(1'b0, 2'd3, 2'd2, 32'h11, E, w);
        send(1'b0, 2'd0, 2'd2, 32'h22, W, w);
        send(1'b0, 2'd1, 2'd0, 32'h33, N, w);
        send(1'b0, 2'd1, 2'd3, 32'h44, N, w);
        send(1'b1, 2'd1, 2'd1, 32'h45, S, w);
        wait_drain("route_drain");

        r_rdy = 1'b0;
        send(1'b1, 2'd2, 2'd2, 32'h100, E, w);
        send(1'b1, 2'd0, 2'd2, 32'h101, W, w);
        send(1'b1, 2'd1, 2'd1, 32'h102, S, w);
        send(1'b1, 2'd1, 2'd2, 32'h103, L, w);
        @(negedge clk);
        check("vc1_full", 64'(vc_full), 64'b10);
        @(posedge clk); #1;
        i_v = 1'b1; i_vc = 1'b1; i_x = 2'd3; i_y = 2'd0; i_data = 32'h104;
        @(negedge clk);
        check("full_refuse", 64'(i_ack), 64'd0);
        @(posedge clk); #1;
        send(1'b0, 2'd1, 2'd0, 32'h200, N, w);
        check("vc0_ack_while_vc1_full", 64'(w), 64'd0);
        check("vc_full_still", 64'(vc_full), 64'b10);

        i_v = 1'b1; i_vc = 1'b1; i_x = 2'd3; i_y = 2'd0; i_data = 32'h104;
        r_rdy = 1'b1;
        @(negedge clk);
        check("no_bypass_refuse", 64'(i_ack), 64'd0);
        @(posedge clk); #1;
        r_rdy = 1'b0;
        @(negedge clk);
        check("ack_after_pop", 64'(i_ack), 64'd1);
        q1.push_back('{x: 2'd3, y: 2'd0, data: 32'h104, dir: E});
        @(posedge clk); #1;
        i_v = 1'b0;
        r_rdy = 1'b1;
        wait_drain("full_drain");

        r_rdy = 1'b0;
        send(1'b0, 2'd1, 2'd2, 32'h300, L, w);
        send(1'b1, 2'd2, 2'd2, 32'h310, E, w);
        send(1'b0, 2'd0, 2'd2, 32'h301, W, w);
        send(1'b1, 2'd1, 2'd3, 32'h311, N, w);
        send(1'b0, 2'd1, 2'd1, 32'h302, S, w);
        send(1'b1, 2'd3, 2'd3, 32'h312, E, w);
        vc_log.delete();
        pop_cyc.delete();
        r_rdy = 1'b1;
        wait_drain("rr_drain");
        check("rr_count", 64'(vc_log.size()), 64'd6);
        if (vc_log.size() == 6) begin
            for (int i = 0; i < 6; i++)
                check("rr_vc_order", 64'(vc_log[i]), 64'(exp_seq[i]));
            check("rr_back_to_back", 64'(pop_cyc[5] - pop_cyc[0]), 64'd5);
        end

        r_rdy = 1'b0;
        send(1'b0, 2'd1, 2'd3, 32'h5555_0001, N, w);
        @(negedge clk);
        check("stable_v", 64'(r_v), 64'd1);
        check("stable_vc0", 64'(r_vc), 64'd0);
        check("stable_data0", 64'(r_data), 64'h5555_0001);
        @(posedge clk); #1;
        send(1'b1, 2'd2, 2'd2, 32'h66, E, w);
        repeat (2) @(negedge clk);
        check("stable_vc1", 64'(r_vc), 64'd0);
        check("stable_data1", 64'(r_data), 64'h5555_0001);
        @(posedge clk); #1;
        i_v = 1'b1; i_vc = 1'b1; i_x = 2'd0; i_y = 2'd0; i_data = 32'h77;
        #1;
        check("ack_before_rst", 64'(i_ack), 64'd1);
        rst = 1'b0;
        #1;
        check("rst_mid_r_v", 64'(r_v), 64'd0);
        check("rst_mid_i_ack", 64'(i_ack), 64'd0);
        q0.delete();
        q1.delete();
        @(posedge clk); #1;
        i_v = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_r_v", 64'(r_v), 64'd0);
        check("post_rst_vc_full", 64'(vc_full), 64'd0);
        @(posedge clk); #1;
        r_rdy = 1'b1;
        vc_log.delete();
        send(1'b1, 2'd1, 2'd2, 32'h99, L, w);
        wait_drain("post_rst_drain");
        check("post_rst_one_pop", 64'(vc_log.size()), 64'd1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/inj_port_rx.md
Name: inj_port_rx

Overview:
- Router-side responder for the client injection interface (i_v / i_vc / i_x / i_y / i_data / i_ack).
- Accepts flits from the attached client into per-VC FIFOs and acknowledges each accepted flit with a one-cycle i_ack.
- Arbitrates round-robin among non-empty VCs and presents one flit per cycle to the router switch stage.
- Tags each presented flit with its torus dimension-order output direction.

Parameters:
- VC_W, 1, VC index width; N_VC = 1 << VC_W.
- X_W, 2, X coordinate width; X_MAX = 1 << X_W.
- Y_W, 2, Y coordinate width; Y_MAX = 1 << Y_W.
- X, 0, this router's X coordinate.
- Y, 0, this router's Y coordinate.
- D_W, 32, flit data width.
- DEPTH, 4, entries per VC FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_v  in  1  client flit valid; held high until acknowledged.
- i_vc  in  VC_W  requested VC.
- i_x  in  X_W  destination X.
- i_y  in  Y_W  destination Y.
- i_data  in  D_W  payload.
- i_ack  out  1  acceptance pulse; transfer occurs on an edge where i_v and i_ack are both 1.
- r_v  out  1  flit valid toward the switch.
- r_vc  out  VC_W  VC of the presented flit.
- r_x  out  X_W  destination X.
- r_y  out  Y_W  destination Y.
- r_data  out  D_W  payload.
- r_dir  out  3  route: 0=E, 1=W, 2=N, 3=S, 4=LOCAL.
- r_rdy  in  1  switch accepts the presented flit.
- vc_full  out  N_VC  per-VC FIFO full flags (registered count equals DEPTH).

Behaviour:
- Reset (rst=0, asynchronous):
  - all FIFO pointers and counts go to 0;
  - round-robin pointer goes to 0; grant lock is cleared;
  - r_v=0, i_ack=0, vc_full=0;
  - r_vc/r_x/r_y/r_data/r_dir are don't-care while r_v=0.
- Acceptance:
  - i_ack = rst & i_v & ~vc_full[i_vc], combinational.
  - On a push, {i_x, i_y, i_data} is written to FIFO[i_vc].
  - At most one push per cycle.
- Full rule: full is judged on the registered count. A push to a full VC is refused even if the same VC pops in that cycle (no bypass). i_v stays high and is acked the next cycle.
- Latency: a flit pushed at edge t can appear on r_v in cycle t+1 at the earliest. There is no combinational path from i_* to r_*.
- Arbitration:
  - Candidates are the non-empty VCs.
  - Search starts at (last_granted + 1) mod N_VC.
  - Once r_v=1, the grant is locked. r_vc/r_x/r_y/r_data/r_dir stay stable until r_v & r_rdy.
  - On a pop: the FIFO head advances, last_granted takes the popped VC, the lock releases, and a new grant is evaluated in the next cycle. Back-to-back pops are allowed, giving one flit per cycle.
- Simultaneous push and pop:
  - Different VCs: independent.
  - Same, non-full VC: count is unchanged and both pointers advance.
  - Empty VC pushed at edge t: not eligible until cycle t+1 (no fall-through).
- Route computation, combinational from the FIFO head:
  - dx = (r_x - X) mod X_MAX, unsigned X_W-bit subtract.
  - dx != 0: r_dir = E if dx <= X_MAX/2, else W. Tie at X_MAX/2 goes to E.
  - dx == 0: dy = (r_y - Y) mod Y_MAX. dy != 0: N if dy <= Y_MAX/2, else S.
  - dx == 0 and dy == 0: r_dir = LOCAL.
- Wrap-around: FIFO pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Reset mid-operation: all contents are discarded. i_ack drops immediately (asynchronous term).

Decomposition:
- Package noc_pkg holds:
  - the direction enum (DIR_E, DIR_W, DIR_N, DIR_S, DIR_LOCAL, 3-bit);
  - the flit struct {x, y, data};
  - a function torus_route(x, y, X, Y).
- Sub-module vc_fifo: one per VC, depth DEPTH. Ports push, pop, din, dout, empty, full.
- The arbiter and route logic stay in the top level.

Test Plan (defaults, X=1, Y=2):
- Reset release, i_v=1, i_vc=0, i_x=1, i_y=2, i_data=0xA5, r_rdy=1 -> i_ack=1 that cycle; next cycle r_v=1, r_vc=0, r_dir=LOCAL, r_data=0xA5.
- Route boundaries, with r_rdy=1:
  - i_x=3 -> dx=2 (tie), r_dir=E.
  - i_x=0 -> dx=3, r_dir=W.
  - i_x=1, i_y=0 -> dy=2, r_dir=N.
  - i_x=1, i_y=3 -> dy=1, r_dir=N.
- Fill VC1 with 4 flits and hold r_rdy=0 -> vc_full=2'b10; a 5th i_v on VC1 gets i_ack=0. A simultaneous i_v on VC0 is still acked.
- Full VC1, set r_rdy=1 for one cycle while a push to VC1 is pending -> the push is refused that cycle and acked the next. Pop order equals push order.
- Both VCs loaded with 3 flits each, r_rdy=1 -> r_vc sequence 0,1,0,1,0,1 with r_v continuous.
- With r_rdy=0, a flit presented on VC0, then a push to VC1 -> r_vc/r_data unchanged until r_rdy=1. Then assert rst=0 mid-stream -> r_v=0 and i_ack=0 immediately; after release all FIFOs are empty.
